// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// ----------------
// Round-robin arbiter that shares one dual-read / single-write data memory
// between two requesters, m0 and m1. It accepts one command at a time. It
// drives the memory address, write data and the memread/memwrite strobes
// for exactly one cycle. It returns read data to the requester that owns
// the command, together with a one-cycle rvalid pulse.
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   mX_req, mX_we               request and operation (1 = write, 0 = dual read)
//   mX_addrA, mX_addrB          read addresses (addrA is also the write address)
//   mX_wdata                    write data
//   mX_gnt                      one-cycle pulse: command accepted
//   mX_rvalid                   one-cycle pulse: rdataA/rdataB/err belong to mX
//   rdataA, rdataB              shared read-data registers
//   err                         address-range error, qualified by gnt (write)
//                               or rvalid (read)
//   mem_addrA/B/WR, mem_write_data, mem_memread, mem_memwrite  to memory
//   mem_read_dataA/B            from memory, registered by the memory when
//                               memread is high
//
// Command timeline (cycle N = IDLE cycle that samples req):
//   N+1 ISSUE : gnt, plus strobe (or err for a bad address)
//   N+2 RESP  : memory output valid, captured into rdataA/rdataB (reads only)
//   N+3 IDLE  : rvalid, and the next arbitration in parallel
module mem_port_arbiter #(
  parameter int DEPTH = 32,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m1_req,
  input  logic          m0_we,
  input  logic          m1_we,
  input  logic [AW-1:0] m0_addrA,
  input  logic [AW-1:0] m1_addrA,
  input  logic [AW-1:0] m0_addrB,
  input  logic [AW-1:0] m1_addrB,
  input  logic [DW-1:0] m0_wdata,
  input  logic [DW-1:0] m1_wdata,
  output logic          m0_gnt,
  output logic          m1_gnt,
  output logic          m0_rvalid,
  output logic          m1_rvalid,
  output logic [DW-1:0] rdataA,
  output logic [DW-1:0] rdataB,
  output logic          err,
  output logic [AW-1:0] mem_addrA,
  output logic [AW-1:0] mem_addrB,
  output logic [AW-1:0] mem_addrWR,
  output logic [DW-1:0] mem_write_data,
  output logic          mem_memread,
  output logic          mem_memwrite,
  input  logic [DW-1:0] mem_read_dataA,
  input  logic [DW-1:0] mem_read_dataB
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

  // Returns 1 when an address falls outside the memory.
  function automatic logic addr_bad(input logic [AW-1:0] addr);
    return (addr >= DEPTH_A);
  endfunction

  state_t state_r;
  logic   owner_r;     // 0 = m0, 1 = m1
  logic   op_we_r;     // operation of the command in flight
  logic   op_err_r;    // command in flight has a bad address
  logic   prio_r;      // requester favoured on a tie (0 = m0)

  logic          any_req_s;
  logic          win_s;
  logic          sel_we_s;
  logic [AW-1:0] sel_addr_a_s;
  logic [AW-1:0] sel_addr_b_s;
  logic [DW-1:0] sel_wdata_s;
  logic          sel_err_s;

  // Winner selection and command mux for the IDLE-state arbitration.
  always_comb begin
    any_req_s = m0_req | m1_req;
    if (m0_req && m1_req) begin
      win_s = prio_r;
    end else if (m1_req) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end

    if (win_s) begin
      sel_we_s     = m1_we;
      sel_addr_a_s = m1_addrA;
      sel_addr_b_s = m1_addrB;
      sel_wdata_s  = m1_wdata;
    end else begin
      sel_we_s     = m0_we;
      sel_addr_a_s = m0_addrA;
      sel_addr_b_s = m0_addrB;
      sel_wdata_s  = m0_wdata;
    end

    // A write ignores addrB, so only addrA can make it fail.
    if (sel_we_s) begin
      sel_err_s = addr_bad(sel_addr_a_s);
    end else begin
      sel_err_s = addr_bad(sel_addr_a_s) | addr_bad(sel_addr_b_s);
    end
  end

  // Control FSM; every output is a register updated here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= IDLE;
      owner_r        <= 1'b0;
      op_we_r        <= 1'b0;
      op_err_r       <= 1'b0;
      prio_r         <= 1'b0;
      m0_gnt         <= 1'b0;
      m1_gnt         <= 1'b0;
      m0_rvalid      <= 1'b0;
      m1_rvalid      <= 1'b0;
      err            <= 1'b0;
      mem_memread    <= 1'b0;
      mem_memwrite   <= 1'b0;
      rdataA         <= {DW{1'b0}};
      rdataB         <= {DW{1'b0}};
      mem_addrA      <= {AW{1'b0}};
      mem_addrB      <= {AW{1'b0}};
      mem_addrWR     <= {AW{1'b0}};
      mem_write_data <= {DW{1'b0}};
    end else begin
      // Pulse outputs fall back to 0 unless a state below raises them.
      m0_gnt       <= 1'b0;
      m1_gnt       <= 1'b0;
      m0_rvalid    <= 1'b0;
      m1_rvalid    <= 1'b0;
      err          <= 1'b0;
      mem_memread  <= 1'b0;
      mem_memwrite <= 1'b0;

      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            owner_r        <= win_s;
            op_we_r        <= sel_we_s;
            op_err_r       <= sel_err_s;
            prio_r         <= ~win_s;   // the requester that lost gets the next tie
            mem_addrA      <= sel_addr_a_s;
            mem_addrB      <= sel_addr_b_s;
            mem_addrWR     <= sel_addr_a_s;
            mem_write_data <= sel_wdata_s;
            // The gnt and strobe registers are loaded here so that they are
            // high for the whole ISSUE cycle.
            m0_gnt         <= ~win_s;
            m1_gnt         <= win_s;
            err            <= sel_err_s;
            mem_memread    <= ~sel_we_s & ~sel_err_s;
            mem_memwrite   <= sel_we_s & ~sel_err_s;
            state_r        <= ISSUE;
          end else begin
            state_r <= IDLE;
          end
        end

        ISSUE: begin
          if (op_we_r) begin
            state_r <= IDLE;
          end else begin
            state_r <= RESP;
          end
        end

        RESP: begin
          // The memory output became valid at the end of ISSUE.
          if (op_err_r) begin
            rdataA <= {DW{1'b0}};
            rdataB <= {DW{1'b0}};
          end else begin
            rdataA <= mem_read_dataA;
            rdataB <= mem_read_dataB;
          end
          m0_rvalid <= ~owner_r;
          m1_rvalid <= owner_r;
          err       <= op_err_r;
          state_r   <= IDLE;
        end

        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        e;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [1:0]    req;
  logic [1:0]    we;
  logic [AW-1:0] addr_a [2];
  logic [AW-1:0] addr_b [2];
  logic [DW-1:0] wdata  [2];
  wire  [1:0]    gnt;
  wire  [1:0]    rvalid;
  logic [DW-1:0] rdata_a, rdata_b;
  logic          err;
  logic [AW-1:0] mem_addr_a, mem_addr_b, mem_addr_wr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rd, mem_wr;
  logic [DW-1:0] mem_rdata_a, mem_rdata_b;

  // memory model and the bench's own reference copy
  logic [DW-1:0] mem [32];
  logic [DW-1:0] ref_mem [32];
  logic          mem_init_done = 1'b0;

  exp_t q0 [$];
  exp_t q1 [$];
  int   gnt_who [$];
  int   gnt_cyc [$];
  int   cyc = 0;

  int checks = 0;
  int failures = 0;

  mem_port_arbiter #(.DEPTH(32), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(rst),
    .m0_req(req[0]), .m1_req(req[1]),
    .m0_we(we[0]), .m1_we(we[1]),
    .m0_addrA(addr_a[0]), .m1_addrA(addr_a[1]),
    .m0_addrB(addr_b[0]), .m1_addrB(addr_b[1]),
    .m0_wdata(wdata[0]), .m1_wdata(wdata[1]),
    .m0_gnt(gnt[0]), .m1_gnt(gnt[1]),
    .m0_rvalid(rvalid[0]), .m1_rvalid(rvalid[1]),
    .rdataA(rdata_a), .rdataB(rdata_b), .err(err),
    .mem_addrA(mem_addr_a), .mem_addrB(mem_addr_b), .mem_addrWR(mem_addr_wr),
    .mem_write_data(mem_wdata), .mem_memread(mem_rd), .mem_memwrite(mem_wr),
    .mem_read_dataA(mem_rdata_a), .mem_read_dataB(mem_rdata_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_rd) begin
      mem_rdata_a <= mem[mem_addr_a[4:0]];
      mem_rdata_b <= mem[mem_addr_b[4:0]];
    end
  end

  always @(negedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 32; i++) mem[i] <= DW'(i);
      mem_init_done <= 1'b1;
    end else if (mem_wr) begin
      mem[mem_addr_wr[4:0]] <= mem_wdata;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // scoreboard: pop and compare on every rvalid, log every grant
  always @(negedge clk) begin
    if (!rst) begin
      exp_t e;
      if (gnt[0] || gnt[1]) begin
        gnt_who.push_back(gnt[1] ? 1 : 0);
        gnt_cyc.push_back(cyc);
      end
      if (rvalid[0]) begin
        if (q0.size() == 0) check_eq("m0_unexpected_rvalid", 32'd1, 32'd0);
        else begin
          e = q0.pop_front();
          check_eq("m0_rdataA", rdata_a, e.a);
          check_eq("m0_rdataB", rdata_b, e.b);
          check_eq("m0_rd_err", 32'(err), 32'(e.e));
        end
      end
      if (rvalid[1]) begin
        if (q1.size() == 0) check_eq("m1_unexpected_rvalid", 32'd1, 32'd0);
        else begin
          e = q1.pop_front();
          check_eq("m1_rdataA", rdata_a, e.a);
          check_eq("m1_rdataB", rdata_b, e.b);
          check_eq("m1_rd_err", 32'(err), 32'(e.e));
        end
      end
    end
  end

  // Drive one command from requester p and wait (bounded) for its grant.
  task automatic issue(input int p, input logic w, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] d, input bit hold, output int lat);
    exp_t e;
    logic exp_err;
    bit   got;
    exp_err = w ? (a >= 32'd32) : ((a >= 32'd32) || (b >= 32'd32));
    if (!w) begin
      e.a = exp_err ? 32'd0 : ref_mem[a[4:0]];
      e.b = exp_err ? 32'd0 : ref_mem[b[4:0]];
      e.e = exp_err;
      if (p == 0) q0.push_back(e); else q1.push_back(e);
    end else if (!exp_err) begin
      ref_mem[a[4:0]] = d;
    end
    req[p] = 1'b1; we[p] = w; addr_a[p] = a; addr_b[p] = b; wdata[p] = d;
    lat = 0; got = 1'b0;
    while (!got && lat < 50) begin
      @(negedge clk);
      lat++;
      if (gnt[p]) got = 1'b1;
    end
    check_eq("gnt_seen", 32'(got), 32'd1);
    if (got) begin
      check_eq(w ? "wr_err_at_gnt" : "rd_err_at_gnt", 32'(err), 32'(exp_err));
      if (w) begin
        check_eq("memwrite_at_gnt", 32'(mem_wr), 32'(!exp_err));
        check_eq("memread_on_write", 32'(mem_rd), 32'd0);
        if (!exp_err) begin
          check_eq("mem_addrWR", mem_addr_wr, a);
          check_eq("mem_write_data", mem_wdata, d);
        end
      end else begin
        check_eq("memread_at_gnt", 32'(mem_rd), 32'(!exp_err));
        check_eq("memwrite_on_read", 32'(mem_wr), 32'd0);
      end
    end
    if (!hold) req[p] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 2'b00;
    q0.delete();
    q1.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    gnt_who.delete();
    gnt_cyc.delete();
  endtask

  initial begin
    int lat, lat1, k;
    req = 2'b00; we = 2'b00;
    for (int i = 0; i < 2; i++) begin
      addr_a[i] = 32'd0; addr_b[i] = 32'd0; wdata[i] = 32'd0;
    end
    for (int i = 0; i < 32; i++) ref_mem[i] = DW'(i);
    repeat (3) @(negedge clk);
    // reset-state outputs
    check_eq("rst_gnt", 32'(gnt), 32'd0);
    check_eq("rst_rvalid", 32'(rvalid), 32'd0);
    check_eq("rst_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_rdataA", rdata_a, 32'd0);
    check_eq("rst_mem_addrA", mem_addr_a, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: simple read, latency check
    issue(0, 1'b0, 32'd5, 32'd7, 32'd0, 1'b0, lat);
    check_eq("rd_gnt_latency", 32'(lat), 32'd1);
    k = 0;
    while (!rvalid[0] && k < 20) begin @(negedge clk); k++; end
    check_eq("rd_rvalid_after_gnt", 32'(k), 32'd2);
    check_eq("memread_one_cycle", 32'(mem_rd), 32'd0);
    @(negedge clk);

    // 2: m1 write then read back
    issue(1, 1'b1, 32'd3, 32'd0, 32'hDEADBEEF, 1'b0, lat);
    @(negedge clk);
    check_eq("memwrite_one_cycle", 32'(mem_wr), 32'd0);
    issue(1, 1'b0, 32'd3, 32'd3, 32'd0, 1'b0, lat);
    repeat (3) @(negedge clk);

    // 4: range errors, then confirm the bad write did not alias into word 8
    issue(0, 1'b0, 32'd0, 32'd32, 32'd0, 1'b0, lat);
    repeat (3) @(negedge clk);
    issue(1, 1'b1, 32'd40, 32'd0, 32'h12345678, 1'b0, lat);
    @(negedge clk);
    issue(0, 1'b0, 32'd8, 32'd31, 32'd0, 1'b0, lat);
    repeat (3) @(negedge clk);

    // 3: both request continuously from reset -> strict alternation
    do_reset();
    fork
      begin
        for (int i = 0; i < 3; i++) issue(0, 1'b0, 32'(i), 32'(i + 1), 32'd0, i < 2, lat);
      end
      begin
        for (int j = 0; j < 3; j++) issue(1, 1'b0, 32'(10 + j), 32'(20 + j), 32'd0, j < 2, lat1);
      end
    join
    repeat (4) @(negedge clk);
    check_eq("alt_grant_count", 32'(gnt_who.size()), 32'd6);
    for (int i = 0; i < gnt_who.size() && i < 6; i++) begin
      check_eq("alt_grant_owner", 32'(gnt_who[i]), 32'(i % 2));
      if (i > 0) check_eq("alt_grant_spacing", 32'(gnt_cyc[i] - gnt_cyc[i-1]), 32'd3);
    end

    // 5: reset during RESP of an m1 read drops it; next tie goes to m0
    issue(1, 1'b0, 32'd4, 32'd6, 32'd0, 1'b0, lat);
    @(negedge clk);              // now in RESP
    rst = 1'b1;
    q1.delete();
    @(negedge clk);
    check_eq("rst_mid_rvalid", 32'(rvalid), 32'd0);
    rst = 1'b0;
    gnt_who.delete();
    gnt_cyc.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("no_m1_rvalid_after_rst", 32'(rvalid[1]), 32'd0);
    end
    fork
      issue(0, 1'b0, 32'd9, 32'd10, 32'd0, 1'b0, lat);
      issue(1, 1'b0, 32'd11, 32'd12, 32'd0, 1'b0, lat1);
    join
    repeat (4) @(negedge clk);
    check_eq("post_rst_first_grant", gnt_who.size() > 0 ? 32'(gnt_who[0]) : 32'hFFFF_FFFF, 32'd0);

    // 6: held req issues two back-to-back reads
    gnt_who.delete();
    issue(0, 1'b0, 32'd1, 32'd1, 32'd0, 1'b1, lat);
    issue(0, 1'b0, 32'd2, 32'd2, 32'd0, 1'b0, lat);
    repeat (4) @(negedge clk);
    check_eq("held_req_grants", 32'(gnt_who.size()), 32'd2);

    k = 0;
    while ((q0.size() != 0 || q1.size() != 0) && k < 20) begin @(negedge clk); k++; end
    check_eq("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Round-robin arbiter sharing the dual-read / single-write 32-word data memory between two requesters, m0 and m1.
- Accepts one command at a time from the winning requester and drives the memory's address, data and memread/memwrite strobes for exactly one cycle.
- Returns read data to the owning requester with a registered rvalid pulse.
- Sits between the memory block and its clients, e.g. a datapath master and a loader/debug master.

Parameters:
- DEPTH, 32: number of memory words; any address >= DEPTH is an error.
- AW, 32: width of all address ports.
- DW, 32: data width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- m0_req, m1_req  in  1 each  request; held with command stable until the matching gnt is seen.
- m0_we, m1_we  in  1 each  1 = write, 0 = dual read.
- m0_addrA, m1_addrA  in  AW each  read port A address; also the write address when we=1.
- m0_addrB, m1_addrB  in  AW each  read port B address; ignored on writes.
- m0_wdata, m1_wdata  in  DW each  write data.
- m0_gnt, m1_gnt  out  1 each  one-cycle pulse: command accepted.
- m0_rvalid, m1_rvalid  out  1 each  one-cycle pulse: rdataA/rdataB/err valid for this requester.
- rdataA, rdataB  out  DW each  shared read-data registers.
- err  out  1  address-range error; qualified by gnt (write) or rvalid (read).
- mem_addrA, mem_addrB, mem_addrWR  out  AW each  to memory.
- mem_write_data  out  DW  to memory.
- mem_memread, mem_memwrite  out  1 each  to memory.
- mem_read_dataA, mem_read_dataB  in  DW each  from memory; registered by the memory on posedge when memread=1.

Behaviour:
- Reset (async): state=IDLE, rr pointer favours m0, all gnt/rvalid/err/memread/memwrite=0, all address, data and rdata registers=0.
- States:
  - IDLE: sample m0_req/m1_req.
    - None high: stay in IDLE.
    - Otherwise pick the winner: if exactly one requests, it wins; if both request, the requester not served last wins; after reset m0 wins.
    - Register the winner's command into the mem_* outputs, set owner and op. Go to ISSUE.
  - ISSUE: gnt[owner]=1 for this cycle only.
    - Valid read: memread=1 this cycle; the memory captures at the end-of-cycle posedge.
    - Valid write: memwrite=1 this cycle; the memory writes at mid-cycle negedge; mem_addrWR=addrA.
    - Error (write: addrA>=DEPTH; read: addrA or addrB >=DEPTH): both strobes stay 0, err=1 alongside gnt. A write error is reported only here.
    - Next state: read -> RESP, write -> IDLE.
  - RESP: capture mem_read_dataA/B into rdataA/rdataB; for an error read capture 0 instead. Next state IDLE; rvalid[owner]=1 and err (error flag) in the following cycle only.
- Strobes are high only in ISSUE. mem_addr*/mem_write_data hold their last value otherwise. rdata holds until the next read completes.
- Latency:
  - Read: req sampled in cycle N, gnt in N+1, rvalid and data in N+3.
  - Write: gnt in N+1, data stored at the negedge of N+1.
  - Minimum spacing between commands is 3 cycles for reads and 2 for writes.
- req is sampled only in IDLE. A requester holding req high after gnt issues a new command.
- The rvalid cycle coincides with IDLE, so the next arbitration overlaps it.
- rr pointer updates on every grant, including error grants.
- Reset mid-op:
  - Any pending read is dropped; no rvalid.
  - A write whose memwrite was cleared by reset before the ISSUE negedge does not occur.
  - The rr pointer returns to favouring m0.

Test Plan:
- After reset, m0 reads addrA=5, addrB=7 (memory initialised MEMO[i]=i) -> m0_gnt at N+1, memread high 1 cycle, m0_rvalid at N+3 with rdataA=5, rdataB=7, err=0.
- m1 writes addrA=3, wdata=0xDEADBEEF, then reads addrA=3, addrB=3 -> memwrite 1 cycle with mem_addrWR=3; rdataA=rdataB=0xDEADBEEF.
- m0 and m1 both request reads continuously from reset -> grants alternate m0, m1, m0, m1; each rvalid goes only to the owner, 3 cycles per read.
- m0 reads addrB=32 -> gnt, memread stays 0, m0_rvalid with err=1, rdataA=rdataB=0. m1 writes addrA=40 -> err with gnt, memwrite stays 0, memory unchanged.
- Reset asserted during RESP of an m1 read -> no m1_rvalid; next simultaneous request is granted to m0.
- Requester holds req through gnt for two reads (addr 1, then 2) -> two separate grants; rdataA=1 then 2.
